// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: FSM state
// encoding, opcodes and the datapath select/ALU/immediate encodings.
package riscv_ctrl_pkg;

  localparam int unsigned OP_W  = 7;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned ALU_W = 3;
  localparam int unsigned IMM_W = 3;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [3:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALR2,
    S_LUI,
    S_TRAP
  } state_e;

  // Opcodes
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

  // ALU operations
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;

  // Immediate formats
  localparam logic [IMM_W-1:0] IMM_I = 3'b000;
  localparam logic [IMM_W-1:0] IMM_S = 3'b001;
  localparam logic [IMM_W-1:0] IMM_B = 3'b010;
  localparam logic [IMM_W-1:0] IMM_U = 3'b011;
  localparam logic [IMM_W-1:0] IMM_J = 3'b100;

  // Result bus sources
  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_READDATA  = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;
  localparam logic [SEL_W-1:0] RES_IMMEXT    = 2'b11;

  // ALU operand A sources
  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

  // ALU operand B sources
  localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  // Immediate format implied by the opcode (I-format for anything unlisted).
  function automatic logic [IMM_W-1:0] imm_src_for(input logic [OP_W-1:0] op);
    logic [IMM_W-1:0] imm;
    case (op)
      OP_STORE:  imm = IMM_S;
      OP_BRANCH: imm = IMM_B;
      OP_JAL:    imm = IMM_J;
      OP_LUI:    imm = IMM_U;
      default:   imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder shared with the single-cycle core.
// Ports: op/func3/func7_5 (instruction fields) -> alu_control_c (ALU op),
//        legal_c (0 when func3 is not supported for an R/I/branch opcode).
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  input  logic [F3_W-1:0]  func3,
  input  logic             func7_5,
  output logic [ALU_W-1:0] alu_control_c,
  output logic             legal_c
);

  // Only add/sub/slt/or/and and beq/bne are implemented.
  always_comb begin
    alu_control_c = ALU_ADD;
    legal_c       = 1'b1;
    case (op)
      OP_RTYPE, OP_ITYPE: begin
        case (func3)
          3'b000:  alu_control_c = (op == OP_RTYPE && func7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_c = ALU_SLT;
          3'b110:  alu_control_c = ALU_OR;
          3'b111:  alu_control_c = ALU_AND;
          default: legal_c = 1'b0;
        endcase
      end
      OP_BRANCH: begin
        alu_control_c = ALU_SUB;
        legal_c       = (func3 == 3'b000) || (func3 == 3'b001);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multi-cycle RV32I core (shared memory port
// and ALU). Steps the datapath state by state from the latched opcode.
// Inputs : clk, reset_n, op/func3/func7_5 (IR fields), ZeroFlag, mem_ready.
// Outputs: mem_req/AdrSrc/MemWrite (memory handshake), IRWrite/PCWrite/
//          RegWrite strobes, ResultSrc/ALUSrcA/ALUSrcB selects, ALUcontrol,
//          ImmSrc, sticky illegal_instr and retired-instruction count instret.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [OP_W-1:0]  op,
  input  logic [F3_W-1:0]  func3,
  input  logic             func7_5,
  input  logic             ZeroFlag,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [SEL_W-1:0] ResultSrc,
  output logic [SEL_W-1:0] ALUSrcA,
  output logic [SEL_W-1:0] ALUSrcB,
  output logic [ALU_W-1:0] ALUcontrol,
  output logic [IMM_W-1:0] ImmSrc,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] instret
);

  state_e             state_q, state_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic [ALU_W-1:0]   dec_alu_c;
  logic               dec_legal_c;
  logic               retire_c;

  alu_decoder u_alu_decoder (
    .op            (op),
    .func3         (func3),
    .func7_5       (func7_5),
    .alu_control_c (dec_alu_c),
    .legal_c       (dec_legal_c)
  );

  // State and counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_START;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  // Next state and datapath controls (Moore, except mem_ready/ZeroFlag-qualified strobes)
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUcontrol = ALU_ADD;
    ImmSrc     = IMM_I;
    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute branch/jal target into ALUOut
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = imm_src_for(op);
        if (!dec_legal_c) begin
          state_d = S_TRAP;
        end else begin
          case (op)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_RTYPE:          state_d = S_EXECR;
            OP_ITYPE:          state_d = S_EXECI;
            OP_BRANCH:         state_d = S_BRANCH;
            OP_JAL:            state_d = S_JAL;
            OP_JALR:           state_d = S_JALR;
            OP_LUI:            state_d = S_LUI;
            default:           state_d = S_TRAP;
          endcase
        end
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = op[5] ? IMM_S : IMM_I;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_READDATA;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUcontrol = dec_alu_c;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUcontrol = dec_alu_c;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUcontrol = ALU_SUB;
        ResultSrc  = RES_ALUOUT;
        ImmSrc     = IMM_B;
        // beq takes on zero, bne (func3[0]=1) on non-zero
        PCWrite    = ZeroFlag ^ func3[0];
        state_d    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
        ImmSrc    = IMM_J;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = S_JALR2;
      end
      S_JALR2: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        ResultSrc = RES_IMMEXT;
        ImmSrc    = IMM_U;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_START;
    endcase
  end

  // An instruction retires when its final state hands back to FETCH
  always_comb begin
    retire_c = 1'b0;
    if (state_d == S_FETCH) begin
      case (state_q)
        S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_LUI: retire_c = 1'b1;
        default: ;
      endcase
    end
  end

  // Sticky illegal flag and wrapping retire counter
  always_comb begin
    illegal_d = illegal_q | (state_d == S_TRAP);
    instret_d = retire_c ? instret_q + CNT_W'(1) : instret_q;
  end

  assign illegal_instr = illegal_q;
  assign instret       = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  localparam int unsigned CNT_W = 32;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JL   = 7'b1101111;
  localparam logic [6:0] JR   = 7'b1100111;
  localparam logic [6:0] LU   = 7'b0110111;
  localparam logic [6:0] BAD  = 7'b1111111;

  logic             clk;
  logic             reset_n;
  logic [6:0]       op;
  logic [2:0]       func3;
  logic             func7_5;
  logic             ZeroFlag;
  logic             mem_ready;
  logic             mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
  logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]       ALUcontrol, ImmSrc;
  logic             illegal_instr;
  logic [CNT_W-1:0] instret;

  multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .op            (op),
    .func3         (func3),
    .func7_5       (func7_5),
    .ZeroFlag      (ZeroFlag),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .AdrSrc        (AdrSrc),
    .MemWrite      (MemWrite),
    .IRWrite       (IRWrite),
    .PCWrite       (PCWrite),
    .RegWrite      (RegWrite),
    .ResultSrc     (ResultSrc),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ALUcontrol    (ALUcontrol),
    .ImmSrc        (ImmSrc),
    .illegal_instr (illegal_instr),
    .instret       (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: {req,adr,mw,ir,pc,rw,ResultSrc,ALUSrcA,ALUSrcB,ALUcontrol,ImmSrc}
  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f75;
    logic        zf;
    logic        rdy;
    logic [17:0] ctrl;
    logic        ill;
    logic [31:0] cnt;
    string       tag;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [17:0] mk(input logic req, input logic adr, input logic mw,
                                     input logic ir, input logic pc, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] a,
                                     input logic [1:0] b, input logic [2:0] alu,
                                     input logic [2:0] imm);
    return {req, adr, mw, ir, pc, rw, rs, a, b, alu, imm};
  endfunction

  function automatic vec_t mv(input logic r, input logic [6:0] o, input logic [2:0] f3,
                              input logic f75, input logic zf, input logic rd,
                              input logic [17:0] c, input logic il, input logic [31:0] n,
                              input string t);
    vec_t e;
    e.rst = r; e.op = o; e.f3 = f3; e.f75 = f75; e.zf = zf; e.rdy = rd;
    e.ctrl = c; e.ill = il; e.cnt = n; e.tag = t;
    return e;
  endfunction

  // Drive one cycle of inputs, compare outputs, then advance one clock.
  task automatic apply(input vec_t e, input int idx);
    logic [17:0] act;
    reset_n = e.rst; op = e.op; func3 = e.f3; func7_5 = e.f75;
    ZeroFlag = e.zf; mem_ready = e.rdy;
    #1;
    act = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUcontrol, ImmSrc};
    checks++;
    if (act !== e.ctrl) begin
      failures++;
      $display("FAIL %s[%0d] ctrl got=%b want=%b", e.tag, idx, act, e.ctrl);
    end
    checks++;
    if (illegal_instr !== e.ill) begin
      failures++;
      $display("FAIL %s[%0d] illegal_instr got=%b want=%b", e.tag, idx, illegal_instr, e.ill);
    end
    checks++;
    if (instret !== e.cnt) begin
      failures++;
      $display("FAIL %s[%0d] instret got=%0d want=%0d", e.tag, idx, instret, e.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  logic [17:0] C0, C_FETCH, C_FWAIT, C_MADR_L, C_MADR_S, C_MRD, C_MWB, C_MWR;
  logic [17:0] C_AWB, C_JAL, C_JALR, C_JALR2, C_LUI;

  function automatic logic [17:0] c_dec(input logic [2:0] imm);
    return mk(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, imm);
  endfunction
  function automatic logic [17:0] c_exr(input logic [2:0] alu);
    return mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, alu, 3'b000);
  endfunction
  function automatic logic [17:0] c_exi(input logic [2:0] alu);
    return mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, alu, 3'b000);
  endfunction
  function automatic logic [17:0] c_br(input logic pc);
    return mk(0,0,0,0,pc,0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010);
  endfunction

  initial begin
    C0       = '0;
    C_FETCH  = mk(1,0,0,1,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000);
    C_FWAIT  = mk(1,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000);
    C_MADR_L = mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000);
    C_MADR_S = mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001);
    C_MRD    = mk(1,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    C_MWB    = mk(0,0,0,0,0,1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000);
    C_MWR    = mk(1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    C_AWB    = mk(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    C_JAL    = mk(0,0,0,0,1,0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b100);
    C_JALR   = mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000);
    C_JALR2  = mk(0,0,0,0,1,0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000);
    C_LUI    = mk(0,0,0,0,0,1, 2'b11, 2'b00, 2'b00, 3'b000, 3'b011);

    // lw with mem_ready high throughout
    vecs.push_back(mv(0, LW, 3'b010, 0, 0, 1, C0,        0, 0,  "rst"));
    vecs.push_back(mv(1, LW, 3'b010, 0, 0, 1, C0,        0, 0,  "start"));
    vecs.push_back(mv(1, LW, 3'b010, 0, 0, 1, C_FETCH,   0, 0,  "lw_fetch"));
    vecs.push_back(mv(1, LW, 3'b010, 0, 0, 1, c_dec(3'b000), 0, 0, "lw_dec"));
    vecs.push_back(mv(1, LW, 3'b010, 0, 0, 1, C_MADR_L,  0, 0,  "lw_madr"));
    vecs.push_back(mv(1, LW, 3'b010, 0, 0, 1, C_MRD,     0, 0,  "lw_mrd"));
    vecs.push_back(mv(1, LW, 3'b010, 0, 0, 1, C_MWB,     0, 0,  "lw_mwb"));
    // sw with three wait cycles
    vecs.push_back(mv(1, SW, 3'b010, 0, 0, 1, C_FETCH,   0, 1,  "sw_fetch"));
    vecs.push_back(mv(1, SW, 3'b010, 0, 0, 1, c_dec(3'b001), 0, 1, "sw_dec"));
    vecs.push_back(mv(1, SW, 3'b010, 0, 0, 1, C_MADR_S,  0, 1,  "sw_madr"));
    vecs.push_back(mv(1, SW, 3'b010, 0, 0, 0, C_MWR,     0, 1,  "sw_wait"));
    vecs.push_back(mv(1, SW, 3'b010, 0, 0, 0, C_MWR,     0, 1,  "sw_wait"));
    vecs.push_back(mv(1, SW, 3'b010, 0, 0, 0, C_MWR,     0, 1,  "sw_wait"));
    vecs.push_back(mv(1, SW, 3'b010, 0, 0, 1, C_MWR,     0, 1,  "sw_mwr"));
    // sub
    vecs.push_back(mv(1, RT, 3'b000, 1, 0, 1, C_FETCH,   0, 2,  "sub_fetch"));
    vecs.push_back(mv(1, RT, 3'b000, 1, 0, 1, c_dec(3'b000), 0, 2, "sub_dec"));
    vecs.push_back(mv(1, RT, 3'b000, 1, 0, 1, c_exr(3'b001), 0, 2, "sub_ex"));
    vecs.push_back(mv(1, RT, 3'b000, 1, 0, 1, C_AWB,     0, 2,  "sub_wb"));
    // addi with func7_5 set stays add
    vecs.push_back(mv(1, IT, 3'b000, 1, 0, 1, C_FETCH,   0, 3,  "addi_fetch"));
    vecs.push_back(mv(1, IT, 3'b000, 1, 0, 1, c_dec(3'b000), 0, 3, "addi_dec"));
    vecs.push_back(mv(1, IT, 3'b000, 1, 0, 1, c_exi(3'b000), 0, 3, "addi_ex"));
    vecs.push_back(mv(1, IT, 3'b000, 1, 0, 1, C_AWB,     0, 3,  "addi_wb"));
    // ori
    vecs.push_back(mv(1, IT, 3'b110, 0, 0, 1, C_FETCH,   0, 4,  "ori_fetch"));
    vecs.push_back(mv(1, IT, 3'b110, 0, 0, 1, c_dec(3'b000), 0, 4, "ori_dec"));
    vecs.push_back(mv(1, IT, 3'b110, 0, 0, 1, c_exi(3'b011), 0, 4, "ori_ex"));
    vecs.push_back(mv(1, IT, 3'b110, 0, 0, 1, C_AWB,     0, 4,  "ori_wb"));
    // slt
    vecs.push_back(mv(1, RT, 3'b010, 0, 0, 1, C_FETCH,   0, 5,  "slt_fetch"));
    vecs.push_back(mv(1, RT, 3'b010, 0, 0, 1, c_dec(3'b000), 0, 5, "slt_dec"));
    vecs.push_back(mv(1, RT, 3'b010, 0, 0, 1, c_exr(3'b101), 0, 5, "slt_ex"));
    vecs.push_back(mv(1, RT, 3'b010, 0, 0, 1, C_AWB,     0, 5,  "slt_wb"));
    // beq taken, beq not taken, bne taken
    vecs.push_back(mv(1, BR, 3'b000, 0, 1, 1, C_FETCH,   0, 6,  "beqt_fetch"));
    vecs.push_back(mv(1, BR, 3'b000, 0, 1, 1, c_dec(3'b010), 0, 6, "beqt_dec"));
    vecs.push_back(mv(1, BR, 3'b000, 0, 1, 1, c_br(1'b1), 0, 6,  "beqt_br"));
    vecs.push_back(mv(1, BR, 3'b000, 0, 0, 1, C_FETCH,   0, 7,  "beqn_fetch"));
    vecs.push_back(mv(1, BR, 3'b000, 0, 0, 1, c_dec(3'b010), 0, 7, "beqn_dec"));
    vecs.push_back(mv(1, BR, 3'b000, 0, 0, 1, c_br(1'b0), 0, 7,  "beqn_br"));
    vecs.push_back(mv(1, BR, 3'b001, 0, 0, 1, C_FETCH,   0, 8,  "bne_fetch"));
    vecs.push_back(mv(1, BR, 3'b001, 0, 0, 1, c_dec(3'b010), 0, 8, "bne_dec"));
    vecs.push_back(mv(1, BR, 3'b001, 0, 0, 1, c_br(1'b1), 0, 8,  "bne_br"));
    // jal, jalr, lui
    vecs.push_back(mv(1, JL, 3'b000, 0, 0, 1, C_FETCH,   0, 9,  "jal_fetch"));
    vecs.push_back(mv(1, JL, 3'b000, 0, 0, 1, c_dec(3'b100), 0, 9, "jal_dec"));
    vecs.push_back(mv(1, JL, 3'b000, 0, 0, 1, C_JAL,     0, 9,  "jal_jal"));
    vecs.push_back(mv(1, JL, 3'b000, 0, 0, 1, C_AWB,     0, 9,  "jal_wb"));
    vecs.push_back(mv(1, JR, 3'b000, 0, 0, 1, C_FETCH,   0, 10, "jalr_fetch"));
    vecs.push_back(mv(1, JR, 3'b000, 0, 0, 1, c_dec(3'b000), 0, 10, "jalr_dec"));
    vecs.push_back(mv(1, JR, 3'b000, 0, 0, 1, C_JALR,    0, 10, "jalr_1"));
    vecs.push_back(mv(1, JR, 3'b000, 0, 0, 1, C_JALR2,   0, 10, "jalr_2"));
    vecs.push_back(mv(1, JR, 3'b000, 0, 0, 1, C_AWB,     0, 10, "jalr_wb"));
    vecs.push_back(mv(1, LU, 3'b000, 0, 0, 1, C_FETCH,   0, 11, "lui_fetch"));
    vecs.push_back(mv(1, LU, 3'b000, 0, 0, 1, c_dec(3'b011), 0, 11, "lui_dec"));
    vecs.push_back(mv(1, LU, 3'b000, 0, 0, 1, C_LUI,     0, 11, "lui_lui"));
    // lw abandoned by reset mid-MEMREAD
    vecs.push_back(mv(1, LW, 3'b010, 0, 0, 1, C_FETCH,   0, 12, "lwr_fetch"));
    vecs.push_back(mv(1, LW, 3'b010, 0, 0, 1, c_dec(3'b000), 0, 12, "lwr_dec"));
    vecs.push_back(mv(1, LW, 3'b010, 0, 0, 1, C_MADR_L,  0, 12, "lwr_madr"));
    vecs.push_back(mv(1, LW, 3'b010, 0, 0, 0, C_MRD,     0, 12, "lwr_mrd"));
    vecs.push_back(mv(0, LW, 3'b010, 0, 0, 0, C0,        0, 0,  "lwr_rst"));
    // unsupported opcode traps
    vecs.push_back(mv(1, BAD, 3'b000, 0, 0, 1, C0,       0, 0,  "bad_start"));
    vecs.push_back(mv(1, BAD, 3'b000, 0, 0, 1, C_FETCH,  0, 0,  "bad_fetch"));
    vecs.push_back(mv(1, BAD, 3'b000, 0, 0, 1, c_dec(3'b000), 0, 0, "bad_dec"));
    vecs.push_back(mv(1, BAD, 3'b000, 0, 0, 1, C0,       1, 0,  "bad_trap"));
    vecs.push_back(mv(1, LW,  3'b010, 0, 0, 1, C0,       1, 0,  "bad_stay"));
    vecs.push_back(mv(0, LW,  3'b010, 0, 0, 1, C0,       0, 0,  "bad_rst"));

    reset_n = 1'b1; op = '0; func3 = '0; func7_5 = 1'b0; ZeroFlag = 1'b0; mem_ready = 1'b0;
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Hand sequence: fetch stall, then unsupported R-type func3 traps
    apply(mv(1, RT, 3'b001, 0, 0, 0, C0,      0, 0, "f3bad_start"), 100);
    apply(mv(1, RT, 3'b001, 0, 0, 0, C_FWAIT, 0, 0, "f3bad_fwait"), 101);
    apply(mv(1, RT, 3'b001, 0, 0, 0, C_FWAIT, 0, 0, "f3bad_fwait"), 102);
    apply(mv(1, RT, 3'b001, 0, 0, 1, C_FETCH, 0, 0, "f3bad_fetch"), 103);
    apply(mv(1, RT, 3'b001, 0, 0, 1, c_dec(3'b000), 0, 0, "f3bad_dec"), 104);
    for (int k = 0; k < 3; k++)
      apply(mv(1, RT, 3'b001, 0, 1, 1, C0, 1, 0, "f3bad_trap"), 105 + k);
    // Hand sequence: other branch func3 (blt) traps after a reset
    apply(mv(0, BR, 3'b100, 0, 0, 1, C0,      0, 0, "blt_rst"), 110);
    apply(mv(1, BR, 3'b100, 0, 0, 1, C0,      0, 0, "blt_start"), 111);
    apply(mv(1, BR, 3'b100, 0, 0, 1, C_FETCH, 0, 0, "blt_fetch"), 112);
    apply(mv(1, BR, 3'b100, 0, 0, 1, c_dec(3'b010), 0, 0, "blt_dec"), 113);
    apply(mv(1, BR, 3'b100, 0, 0, 1, C0,      1, 0, "blt_trap"), 114);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
